// File: rtl/i2s_pkg.sv
// Shared types, encodings and elaboration helpers for the I2S capture master.
package i2s_pkg;

  localparam logic [1:0] CH_LEFT  = 2'b00;
  localparam logic [1:0] CH_RIGHT = 2'b01;
  localparam logic [1:0] CH_BOTH  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_RUN,
    ST_DONE
  } cap_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int data_w, input int slot_w, input int sck_div,
                                   input int capture_len, input int fifo_depth);
    return (data_w >= 1) && (data_w < slot_w) && (sck_div >= 1) && (capture_len >= 1) &&
           (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2s_capture_master_if.sv
// Valid/ready sample stream from the capture FIFO to the defect-detection datapath.
interface i2s_capture_master_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] sample_o;
  logic              sample_ch_o;
  logic              sample_valid_o;
  logic              sample_ready_i;

  modport master (output sample_o, sample_ch_o, sample_valid_o, input sample_ready_i);
  modport slave  (input sample_o, sample_ch_o, sample_valid_o, output sample_ready_i);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  // Extra pointer bit separates full from empty when the address bits match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_ok    = push && (!full || pop);
  assign rd_ok    = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_capture_master.sv
// I2S master receiver: SCK/WS generation, MSB-first deserialiser and a frame-aligned
// burst capture into a FIFO drained over a valid/ready stream.
module i2s_capture_master
  import i2s_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SLOT_W      = 16,
  parameter int SCK_DIV     = 4,
  parameter int CAPTURE_LEN = 4096,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                clk_27M,
  input  logic                                rst_n_i,
  input  logic                                arm_i,
  input  logic                                abort_i,
  input  logic [1:0]                          chan_sel_i,
  input  logic                                sd_i,
  output logic                                sck_o,
  output logic                                ws_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                overflow_o,
  output logic [clog2(CAPTURE_LEN+1)-1:0]     cnt_o,
  i2s_capture_master_if.master                strm
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = clog2(FRAME_W);
  localparam int DIV_W   = clog2(SCK_DIV + 1);
  localparam int CNT_W   = clog2(CAPTURE_LEN + 1);

  if (!params_ok(DATA_W, SLOT_W, SCK_DIV, CAPTURE_LEN, FIFO_DEPTH)) begin : g_param_err
    $error("i2s_capture_master: illegal parameter set");
  end

  logic [DIV_W-1:0]  div_cnt;
  logic              sck_tick, sck_rise, sck_fall;
  logic [BIT_W-1:0]  bit_idx, bit_idx_nxt, slot_bit;
  logic              slot_ch, in_data, sample_done, chan_ok, frame_wrap;
  logic [DATA_W-1:0] shift_nxt;
  cap_state_e        state, state_nxt;
  logic              cnt_clr, cnt_inc, flush, push, pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] head_data;
  logic              head_ch;

  assign sck_tick = (div_cnt == DIV_W'(SCK_DIV - 1));
  assign sck_rise = sck_tick && !sck_o;
  assign sck_fall = sck_tick && sck_o;

  always_ff @(posedge clk_27M or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt <= '0;
      sck_o   <= 1'b0;
    end else if (sck_tick) begin
      div_cnt <= '0;
      sck_o   <= !sck_o;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bit_idx_nxt = (bit_idx == BIT_W'(FRAME_W - 1)) ? '0 : bit_idx + 1'b1;
  assign frame_wrap  = sck_fall && (bit_idx == BIT_W'(FRAME_W - 1));

  // WS is derived from the post-advance index so it leads the slot's delay bit.
  always_ff @(posedge clk_27M or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_idx <= '0;
      ws_o    <= 1'b0;
    end else if (sck_fall) begin
      bit_idx <= bit_idx_nxt;
      ws_o    <= (bit_idx_nxt >= BIT_W'(SLOT_W));
    end
  end

  assign slot_ch     = (bit_idx >= BIT_W'(SLOT_W));
  assign slot_bit    = slot_ch ? bit_idx - BIT_W'(SLOT_W) : bit_idx;
  assign in_data     = (slot_bit != '0) && (slot_bit <= BIT_W'(DATA_W));
  assign sample_done = sck_rise && (slot_bit == BIT_W'(DATA_W));
  assign chan_ok     = slot_ch ? (chan_sel_i != CH_LEFT) : (chan_sel_i != CH_RIGHT);

  if (DATA_W > 1) begin : g_shift
    logic [DATA_W-2:0] shift_q;
    always_ff @(posedge clk_27M) begin
      if (sck_rise && in_data) shift_q <= shift_nxt[DATA_W-2:0];
    end
    assign shift_nxt = {shift_q, sd_i};
  end else begin : g_shift_1b
    assign shift_nxt = sd_i;
  end

  always_ff @(posedge clk_27M or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    flush     = 1'b0;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_i && !abort_i) begin
          state_nxt = ST_WAIT_FRAME;
          cnt_clr   = 1'b1;
        end
      end
      ST_WAIT_FRAME: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
          flush     = 1'b1;
        end else if (frame_wrap) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_nxt = ST_IDLE;
          flush     = 1'b1;
        end else if (sample_done && chan_ok) begin
          push    = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_o == CNT_W'(CAPTURE_LEN - 1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Dropped samples still count towards the burst length.
  always_ff @(posedge clk_27M or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o      <= '0;
      overflow_o <= 1'b0;
    end else if (cnt_clr) begin
      cnt_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (cnt_inc) cnt_o <= cnt_o + 1'b1;
      if (push && fifo_full && !pop) overflow_o <= 1'b1;
    end
  end

  assign busy_o = (state == ST_WAIT_FRAME) || (state == ST_RUN);
  assign done_o = (state == ST_DONE);
  assign pop    = !fifo_empty && strm.sample_ready_i;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_27M),
    .rst_n     (rst_n_i),
    .flush     (flush),
    .push      (push),
    .push_data ({slot_ch, shift_nxt}),
    .pop       (pop),
    .pop_data  ({head_ch, head_data}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign strm.sample_valid_o = !fifo_empty;
  assign strm.sample_o       = fifo_empty ? '0 : head_data;
  assign strm.sample_ch_o    = !fifo_empty && head_ch;

endmodule

// File: doc/i2s_capture_master.md
Name: i2s_capture_master

Overview:
- Parametrised I2S master receiver for the microphone front end.
- Generates SCK/WS from clk_27M and deserialises SD, MSB first, using the standard one-bit I2S delay.
- Supports configurable sample/slot widths and left, right or both-channel capture.
- On arm, captures a frame-aligned burst of CAPTURE_LEN samples into a small FIFO, which drains over a valid/ready stream to the defect-detection datapath.

Parameters:
- DATA_W, 8, sample bits kept per slot; legal range 1..SLOT_W-1.
- SLOT_W, 16, SCK cycles per channel slot; one frame is 2*SLOT_W SCK cycles.
- SCK_DIV, 4, clk_27M cycles per SCK half-period; minimum 1.
- CAPTURE_LEN, 4096, samples pushed per armed capture; minimum 1.
- FIFO_DEPTH, 8, output FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk_27M  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- arm_i  in  1  single-cycle pulse; starts a capture
- abort_i  in  1  single-cycle pulse; cancels the capture
- chan_sel_i  in  2  00 left only, 01 right only, 10 or 11 both (L then R)
- sd_i  in  1  serial data from the microphone
- sck_o  out  1  bit clock
- ws_o  out  1  word select; 0 = left, 1 = right
- sample_o  out  DATA_W  FIFO head sample
- sample_ch_o  out  1  channel of the head sample (0 = L, 1 = R)
- sample_valid_o  out  1  FIFO non-empty
- sample_ready_i  in  1  consumer accepts the head sample
- busy_o  out  1  FSM is in WAIT_FRAME or RUN
- done_o  out  1  one-cycle pulse when a capture completes
- overflow_o  out  1  sticky; a sample was dropped because the FIFO was full
- cnt_o  out  clog2(CAPTURE_LEN+1)  samples pushed in the current or last capture

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, divider and bit counter at 0.
- Clock generation (free-running after reset):
  - A divider toggles sck_o every SCK_DIV clk cycles; sck_o is low out of reset.
  - Internal one-cycle strobes sck_rise and sck_fall fire in the cycle sck_o toggles.
- Bit counter:
  - bit_idx runs 0..2*SLOT_W-1 and advances on sck_fall, wrapping to 0.
  - ws_o is registered on sck_fall: 0 for bit_idx < SLOT_W, else 1.
- Slot indexing:
  - slot bit b = bit_idx mod SLOT_W.
- Deserialisation:
  - sd_i is sampled on sck_rise.
  - b = 0 is the delay bit and is ignored.
  - b = 1..DATA_W shift into the shift register MSB first.
  - b > DATA_W is ignored.
- Sample completion:
  - On sck_rise with b == DATA_W, the sample is complete.
  - It is pushed as {ch, data} if the FSM is in RUN and the channel is selected by chan_sel_i.
- FSM (IDLE, WAIT_FRAME, RUN, DONE):
  - IDLE: arm_i moves to WAIT_FRAME and clears cnt_o and overflow_o.
  - WAIT_FRAME: waits for the sck_fall where bit_idx wraps to 0 (WS falling, left-slot start), then moves to RUN. Capture is therefore always frame-aligned; a partial slot is never pushed.
  - RUN: each eligible completion increments cnt_o, whether the sample is stored or dropped. When cnt_o reaches CAPTURE_LEN, move to DONE.
  - DONE: asserts done_o for exactly one cycle, then returns to IDLE. The FIFO keeps draining.
  - arm_i outside IDLE is ignored.
  - abort_i in WAIT_FRAME or RUN returns to IDLE and flushes the FIFO; done_o does not pulse and cnt_o holds its value.
  - abort_i and arm_i asserted in the same cycle: abort wins.
- FIFO:
  - Push while full: the sample is dropped and overflow_o is set.
  - Push and pop in the same cycle while full: both succeed and no overflow is flagged.
  - Pop occurs when sample_valid_o && sample_ready_i.
  - sample_valid_o rises 1 cycle after a push into an empty FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
  - The head must be held stable while valid && !ready.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); sck_o and ws_o go low.

Decomposition:
- Package i2s_pkg holds:
  - chan_sel encodings (CH_LEFT, CH_RIGHT, CH_BOTH)
  - FSM state typedef/encoding
  - clog2 function
  - elaboration-time parameter legality checks
- Sub-module sync_fifo #(WIDTH=DATA_W+1, DEPTH=FIFO_DEPTH), providing full, empty, and simultaneous push/pop.
- The divider, bit counter, shifter and FSM stay in the top module.

Test Plan:
All tests use SCK_DIV=2, SLOT_W=16, DATA_W=8, CAPTURE_LEN=4 unless noted. The bench's I2S slave model drives L=0xA5 and R=0x3C every frame.
1. Reset, then idle 200 cycles -> sck_o period is 4 clk cycles; ws_o toggles every 16 SCK falls; sample_valid_o, busy_o, done_o all stay 0.
2. chan_sel=00, arm, ready=1 -> stream 0xA5 x4 with ch=0; done_o pulses once after the 4th push; cnt_o=4; overflow_o=0.
3. chan_sel=10 -> stream 0xA5, 0x3C, 0xA5, 0x3C with ch 0, 1, 0, 1; done_o pulses after the 2nd frame.
4. FIFO_DEPTH=2, ready=0 throughout the capture -> 2 entries stored; overflow_o=1; done_o still pulses; cnt_o=4. Then raise ready -> exactly 0xA5, 0xA5 delivered.
5. arm_i mid-right-slot -> no push until the next WS fall; the first sample is 0xA5 (left). Second arm_i during RUN -> ignored.
6. abort_i after 2 pushes -> FIFO is flushed, valid=0, no done_o pulse, cnt_o=2. Separately, assert rst_n_i low mid-RUN -> all outputs 0 within the same cycle.
